mips_int_ctrl: RTL and testbench
================================

// Module: mips_int_ctrl
// PURPOSE
//  Vectored interrupt controller that sits directly upstream of the single-cycle MIPS controller.
//  - Synchronises and edge-detects NUM_IRQ external request lines.
//  - Latches them as pending, masks them and picks one by fixed priority.
//  - Drives the CPU's interrupt input and ISR vector, handshaking with int_ack and end-of-interrupt (JEPC).
//  - Is memory-mapped on the data bus beside dmem.
// PARAMETERS
//  NUM_IRQ    4             number of request lines (1..16)
//  BASE_ADDR  32'h0000_0800 byte address of the register window (4 words)
//  VBASE_RST  32'h0000_0080 reset value of VBASE
//  VEC_SHIFT  4             vector = VBASE + (id << VEC_SHIFT)
// PORTS
//  clk        in   1        processor clock
//  reset      in   1        synchronous, active-low reset
//  irq_in     in   NUM_IRQ  async request lines, rising edge = request
//  int_ack    in   1        CPU accepted the interrupt (EPC written this cycle)
//  eoi        in   1        CPU executed JEPC (status_write pulse)
//  bus_we     in   1        data-bus write strobe
//  bus_addr   in   32       data-bus byte address
//  bus_wdata  in   32       data-bus write data
//  bus_hit    out  1        bus_addr falls in the window (top level selects bus_rdata over dmem)
//  bus_rdata  out  32       register read data
//  interrupt  out  1        request to the CPU
//  vector     out  32       ISR address for the CPU PC mux
// BEHAVIOUR
//  Reset (clk edge with reset==0), from any state:
//  - MASK=0, PENDING=0, VBASE=VBASE_RST, id=0; state IDLE.
//  - interrupt=0, vector=VBASE_RST; synchroniser flops cleared.
//  - Pending requests are discarded.
//  Input path, per line: sync1 -> sync2 -> prev; edge = sync2 & ~prev.
//  - A level first sampled at edge k sets PENDING at edge k+2.
//  Registers, word offsets from BASE_ADDR:
//  - +0 MASK: R/W; bit i=1 enables line i.
//  - +4 PENDING: R; write-1-to-clear.
//  - +8 VBASE: R/W; bits [1:0] forced 0.
//  - +C CAUSE: RO = {in_service, 27'b0, id[3:0]}; in_service=1 in SERVICE.
//  - Reads are combinational. Outside the window: bus_hit=0, bus_rdata=0, writes ignored.
//  - Same-cycle edge and W1C on the same bit: the edge wins, bit stays 1.
//  FSM IDLE -> REQ -> SERVICE -> IDLE; registered outputs.
//  - IDLE: if |(PENDING & MASK), latch id = lowest set index (0 is highest priority).
//    Then vector <= VBASE + (id << VEC_SHIFT), interrupt <= 1, go to REQ.
//  - REQ: interrupt held at 1; id and vector frozen.
//    Later higher-priority edges and MASK/PENDING writes do not withdraw the request.
//    On int_ack: interrupt <= 0, PENDING[id] <= 0 (unless a new edge arrives the same cycle), go to SERVICE.
//  - SERVICE: no new request (no nesting). eoi -> IDLE. Arbitration resumes on the next cycle.
//  - int_ack outside REQ and eoi outside SERVICE are ignored.
//  - Vector arithmetic is 32-bit modulo; overflow wraps silently.
// STRUCTURE
//  Shared package mips_int_pkg:
//  - register offsets MASK/PENDING/VBASE/CAUSE = 0/4/8/C;
//  - FSM state encoding, 2 bits;
//  - CAUSE field positions.
//  One sub-module: int_sync_edge #(NUM_IRQ), a 2-flop synchroniser plus edge detector.
//  Priority encoder, register file and FSM stay in mips_int_ctrl.
// TESTING
//  1 Reset: hold reset=0 for 2 clocks with irq_in=4'hF -> interrupt=0, vector=32'h80, all registers read 0 except VBASE=32'h80.
//  2 Basic: MASK=4'h4, pulse irq_in[2]:
//    - PENDING=4'h4 two edges after sampling;
//    - interrupt=1 one edge later, vector=32'hA0, CAUSE=2;
//    - int_ack -> interrupt=0, PENDING=0, CAUSE=32'h8000_0002;
//    - eoi -> CAUSE[31]=0.
//  3 Priority/freeze: MASK=4'hF, irq 3 and 1 together -> id=1, vector=32'h90.
//    - irq 0 arriving in REQ -> vector stays 32'h90.
//    - After eoi: next request id=0, vector=32'h80, then id=3.
//  4 Masking/W1C: MASK=0, pulse irq 0 -> PENDING=1, interrupt stays 0.
//    - Write PENDING=1 in the same cycle as a new irq-0 edge -> PENDING stays 1.
//    - MASK=1 -> interrupt=1.
//  5 Spurious handshakes: int_ack in IDLE and eoi in REQ -> no state change, interrupt stays 1.
//  6 Reset mid-operation: reset=0 in SERVICE with PENDING=4'hA -> next edge IDLE, PENDING=0, interrupt=0, VBASE=32'h80.

Source files
------------

// File: rtl/mips_int_pkg.sv
// Shared definitions for the MIPS vectored interrupt controller.
//   - Register word offsets inside the 16-byte window
//   - FSM state encoding (2 bits)
//   - CAUSE register field positions and a packing helper
package mips_int_pkg;

  // Byte offsets of the four registers relative to BASE_ADDR.
  localparam logic [3:0] OFF_MASK    = 4'h0;
  localparam logic [3:0] OFF_PENDING = 4'h4;
  localparam logic [3:0] OFF_VBASE   = 4'h8;
  localparam logic [3:0] OFF_CAUSE   = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // CAUSE = {in_service, 27'b0, id[3:0]}
  localparam int CAUSE_SVC_BIT = 31;
  localparam int CAUSE_ID_LSB  = 0;
  localparam int CAUSE_ID_W    = 4;

  function automatic logic [31:0] cause_word(input logic in_service,
                                             input logic [CAUSE_ID_W-1:0] id);
    logic [31:0] w;
    w = '0;
    w[CAUSE_SVC_BIT] = in_service;
    w[CAUSE_ID_LSB +: CAUSE_ID_W] = id;
    return w;
  endfunction

endpackage

// File: rtl/mips_int_ctrl_sync.sv
// int_sync_edge: two-flop synchroniser plus rising-edge detector, one per
// request line.
//   clk       processor clock
//   reset     synchronous, active-low reset (clears all flops)
//   irq_in    asynchronous request lines
//   irq_edge  one-cycle pulse per line: sync2 & ~prev
module int_sync_edge #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [NUM_IRQ-1:0] irq_edge
);

  logic [NUM_IRQ-1:0] sync1_reg;
  logic [NUM_IRQ-1:0] sync2_reg;
  logic [NUM_IRQ-1:0] prev_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      prev_reg  <= '0;
    end else begin
      sync1_reg <= irq_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_edge
      assign irq_edge[gi] = sync2_reg[gi] & ~prev_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/mips_int_ctrl.sv
// mips_int_ctrl: vectored interrupt controller in front of the single-cycle
// MIPS core. Synchronises/edge-detects request lines, latches them as
// pending, masks them, picks the lowest-numbered one and hands it to the CPU
// with an ISR vector. A 4-word register window sits on the data bus.
//   clk        processor clock
//   reset      synchronous, active-low reset
//   irq_in     async request lines (rising edge = request)
//   int_ack    CPU accepted the interrupt
//   eoi        CPU executed JEPC
//   bus_we/bus_addr/bus_wdata  data-bus write port
//   bus_hit    address falls inside the register window
//   bus_rdata  combinational register read data
//   interrupt  request to the CPU (registered)
//   vector     ISR address (registered)
module mips_int_ctrl
  import mips_int_pkg::*;
#(
  parameter int          NUM_IRQ   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0800,
  parameter logic [31:0] VBASE_RST = 32'h0000_0080,
  parameter int          VEC_SHIFT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               int_ack,
  input  logic               eoi,
  input  logic               bus_we,
  input  logic [31:0]        bus_addr,
  input  logic [31:0]        bus_wdata,
  output logic               bus_hit,
  output logic [31:0]        bus_rdata,
  output logic               interrupt,
  output logic [31:0]        vector
);

  logic [NUM_IRQ-1:0] irq_edge;

  int_sync_edge #(.NUM_IRQ(NUM_IRQ)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .irq_in   (irq_in),
    .irq_edge (irq_edge)
  );

  state_t             state_reg, state_next;
  logic [NUM_IRQ-1:0] mask_reg, mask_next;
  logic [NUM_IRQ-1:0] pending_reg, pending_next;
  logic [31:0]        vbase_reg, vbase_next;
  logic [3:0]         id_reg, id_next;
  logic [31:0]        vector_reg, vector_next;
  logic               interrupt_reg, interrupt_next;

  // Bus decode: the subtraction keeps the window test independent of
  // BASE_ADDR alignment.
  logic [31:0] addr_off;
  logic [3:0]  reg_sel;
  logic        wr_mask, wr_pending, wr_vbase;

  assign addr_off   = bus_addr - BASE_ADDR;
  assign bus_hit    = (addr_off < 32'd16);
  assign reg_sel    = {addr_off[3:2], 2'b00};
  assign wr_mask    = bus_we && bus_hit && (reg_sel == OFF_MASK);
  assign wr_pending = bus_we && bus_hit && (reg_sel == OFF_PENDING);
  assign wr_vbase   = bus_we && bus_hit && (reg_sel == OFF_VBASE);

  always_comb begin
    bus_rdata = '0;
    if (bus_hit) begin
      case (reg_sel)
        OFF_MASK:    bus_rdata = 32'(mask_reg);
        OFF_PENDING: bus_rdata = 32'(pending_reg);
        OFF_VBASE:   bus_rdata = vbase_reg;
        default:     bus_rdata = cause_word(state_reg == ST_SERVICE, id_reg);
      endcase
    end
  end

  // Fixed-priority pick: scanning downward leaves the lowest set index.
  logic [NUM_IRQ-1:0] req;
  logic               req_any;
  logic [3:0]         sel_id;

  always_comb begin
    req     = pending_reg & mask_reg;
    req_any = |req;
    sel_id  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) sel_id = 4'(i);
    end
  end

  // Acknowledge clears the serviced line; a same-cycle edge still re-sets it
  // because edges are OR-ed in after all clears.
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] w1c_clr;

  always_comb begin
    ack_clr = '0;
    if (state_reg == ST_REQ && int_ack) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (id_reg == 4'(i)) ack_clr[i] = 1'b1;
      end
    end
    w1c_clr      = wr_pending ? bus_wdata[NUM_IRQ-1:0] : '0;
    pending_next = (pending_reg & ~(w1c_clr | ack_clr)) | irq_edge;
    mask_next    = wr_mask ? bus_wdata[NUM_IRQ-1:0] : mask_reg;
    vbase_next   = wr_vbase ? {bus_wdata[31:2], 2'b00} : vbase_reg;
  end

  always_comb begin
    state_next     = state_reg;
    id_next        = id_reg;
    vector_next    = vector_reg;
    interrupt_next = interrupt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_any) begin
          id_next        = sel_id;
          vector_next    = vbase_reg + (32'(sel_id) << VEC_SHIFT);
          interrupt_next = 1'b1;
          state_next     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          interrupt_next = 1'b0;
          state_next     = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (eoi) state_next = ST_IDLE;
      end
      default: begin
        interrupt_next = 1'b0;
        state_next     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mask_reg      <= '0;
      pending_reg   <= '0;
      vbase_reg     <= VBASE_RST;
      id_reg        <= '0;
      vector_reg    <= VBASE_RST;
      interrupt_reg <= 1'b0;
    end else begin
      mask_reg      <= mask_next;
      pending_reg   <= pending_next;
      vbase_reg     <= vbase_next;
      id_reg        <= id_next;
      vector_reg    <= vector_next;
      interrupt_reg <= interrupt_next;
    end
  end

  assign interrupt = interrupt_reg;
  assign vector    = vector_reg;

endmodule

// File: tb/tb_mips_int_ctrl.sv
module tb_mips_int_ctrl;

  localparam logic [31:0] BASE = 32'h0000_0800;
  localparam logic [31:0] AM = 32'h800, AP = 32'h804, AV = 32'h808, AC = 32'h80C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  irq_in = '0;
  logic        int_ack = 1'b0, eoi = 1'b0, bus_we = 1'b0;
  logic [31:0] bus_addr = '0, bus_wdata = '0;
  logic        bus_hit, interrupt;
  logic [31:0] bus_rdata, vector;

  mips_int_ctrl dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .int_ack(int_ack), .eoi(eoi),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_hit(bus_hit), .bus_rdata(bus_rdata), .interrupt(interrupt), .vector(vector)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        rst;
    logic [3:0]  irq;
    logic        ack, eo, we;
    logic [31:0] waddr, wdata, raddr;
    logic        exp_int;
    logic [31:0] exp_vec, exp_rd;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rst, input logic [3:0] irq, input logic ack, input logic eo,
                     input logic we, input logic [31:0] waddr, input logic [31:0] wdata,
                     input logic [31:0] raddr, input logic ei, input logic [31:0] ev,
                     input logic [31:0] er);
    vec_t v;
    v = '{rst, irq, ack, eo, we, waddr, wdata, raddr, ei, ev, er};
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  // phase: 0 = waiting for work, 1 = request raised, 2 = in ISR
  logic [3:0]  m_mask, m_pend, h[3];
  logic [31:0] m_vbase, m_vec;
  int          m_id, m_phase;
  logic        m_int;
  bit          model_ok = 0;

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off >= 16) return 32'h0;
    case (off / 4)
      0: return {28'h0, m_mask};
      1: return {28'h0, m_pend};
      2: return m_vbase;
      default: return {(m_phase == 2), 27'h0, 4'(m_id)};
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [3:0] e, clr, rq;
    logic [31:0] off;
    if (!reset) begin
      m_mask = 0; m_pend = 0; m_vbase = 32'h80; m_vec = 32'h80;
      m_id = 0; m_phase = 0; m_int = 0;
      h[0] = 0; h[1] = 0; h[2] = 0;
      model_ok = 1;
      return;
    end
    // a level sampled at edge k appears as an edge at edge k+2
    e   = h[1] & ~h[2];
    off = bus_addr - BASE;
    clr = 0;
    if (bus_we && off < 16 && off / 4 == 1) clr = bus_wdata[3:0];
    rq = m_pend & m_mask;
    case (m_phase)
      0: if (rq != 0) begin
           m_id = lowest(rq); m_vec = m_vbase + 32'(m_id * 16); m_int = 1; m_phase = 1;
         end
      1: if (int_ack) begin
           m_int = 0; clr = clr | (4'b1 << m_id); m_phase = 2;
         end
      default: if (eoi) m_phase = 0;
    endcase
    if (bus_we && off < 16 && off / 4 == 0) m_mask = bus_wdata[3:0];
    if (bus_we && off < 16 && off / 4 == 2) m_vbase = bus_wdata & 32'hFFFF_FFFC;
    m_pend = (m_pend & ~clr) | e;
    h[2] = h[1]; h[1] = h[0]; h[0] = irq_in;
  endtask

  initial begin
    // Reset with all lines high
    add(0, 4'hF, 0, 0, 0, 0, 0, AM, 0, 32'h80, 32'h0);
    add(0, 4'hF, 0, 0, 0, 0, 0, AP, 0, 32'h80, 32'h0);
    add(0, 4'hF, 0, 0, 0, 0, 0, AV, 0, 32'h80, 32'h80);
    add(0, 4'hF, 0, 0, 0, 0, 0, AC, 0, 32'h80, 32'h0);
    // Basic: line 2
    add(1, 4'h0, 0, 0, 1, AM, 32'h4, AM, 0, 32'h80, 32'h4);
    add(1, 4'h4, 0, 0, 0, 0, 0, AP, 0, 32'h80, 32'h0);
    add(1, 4'h0, 0, 0, 0, 0, 0, AP, 0, 32'h80, 32'h0);
    add(1, 4'h0, 0, 0, 0, 0, 0, AP, 0, 32'h80, 32'h4);
    add(1, 4'h0, 0, 0, 0, 0, 0, AC, 1, 32'hA0, 32'h2);
    add(1, 4'h0, 1, 0, 0, 0, 0, AP, 0, 32'hA0, 32'h0);
    add(1, 4'h0, 0, 0, 0, 0, 0, AC, 0, 32'hA0, 32'h8000_0002);
    add(1, 4'h0, 0, 1, 0, 0, 0, AC, 0, 32'hA0, 32'h2);
    // Priority / freeze
    add(1, 4'h0, 0, 0, 1, AM, 32'hF, AM, 0, 32'hA0, 32'hF);
    add(1, 4'hA, 0, 0, 0, 0, 0, AP, 0, 32'hA0, 32'h0);
    add(1, 4'h0, 0, 0, 0, 0, 0, AP, 0, 32'hA0, 32'h0);
    add(1, 4'h0, 0, 0, 0, 0, 0, AP, 0, 32'hA0, 32'hA);
    add(1, 4'h1, 0, 0, 0, 0, 0, AC, 1, 32'h90, 32'h1);
    add(1, 4'h0, 0, 0, 0, 0, 0, AP, 1, 32'h90, 32'hA);
    add(1, 4'h0, 0, 0, 0, 0, 0, AP, 1, 32'h90, 32'hB);
    add(1, 4'h0, 1, 0, 0, 0, 0, AP, 0, 32'h90, 32'h9);
    add(1, 4'h0, 0, 1, 0, 0, 0, AC, 0, 32'h90, 32'h1);
    add(1, 4'h0, 0, 0, 0, 0, 0, AC, 1, 32'h80, 32'h0);
    add(1, 4'h0, 1, 0, 0, 0, 0, AP, 0, 32'h80, 32'h8);
    add(1, 4'h0, 0, 1, 0, 0, 0, AC, 0, 32'h80, 32'h0);
    add(1, 4'h0, 0, 0, 0, 0, 0, AC, 1, 32'hB0, 32'h3);
    add(1, 4'h0, 1, 0, 0, 0, 0, AP, 0, 32'hB0, 32'h0);
    add(1, 4'h0, 0, 1, 0, 0, 0, AC, 0, 32'hB0, 32'h3);
    // Masking and W1C against a same-cycle edge
    add(1, 4'h0, 0, 0, 1, AM, 32'h0, AM, 0, 32'hB0, 32'h0);
    add(1, 4'h1, 0, 0, 0, 0, 0, AP, 0, 32'hB0, 32'h0);
    add(1, 4'h0, 0, 0, 0, 0, 0, AP, 0, 32'hB0, 32'h0);
    add(1, 4'h0, 0, 0, 0, 0, 0, AP, 0, 32'hB0, 32'h1);
    add(1, 4'h1, 0, 0, 0, 0, 0, AP, 0, 32'hB0, 32'h1);
    add(1, 4'h0, 0, 0, 0, 0, 0, AP, 0, 32'hB0, 32'h1);
    add(1, 4'h0, 0, 0, 1, AP, 32'h1, AP, 0, 32'hB0, 32'h1);
    add(1, 4'h0, 0, 0, 1, AM, 32'h1, AM, 0, 32'hB0, 32'h1);
    add(1, 4'h0, 0, 0, 0, 0, 0, AC, 1, 32'h80, 32'h0);
    // Spurious handshakes
    add(1, 4'h0, 0, 1, 0, 0, 0, AC, 1, 32'h80, 32'h0);
    add(1, 4'h0, 1, 0, 0, 0, 0, AP, 0, 32'h80, 32'h0);
    add(1, 4'h0, 0, 1, 0, 0, 0, AC, 0, 32'h80, 32'h0);
    add(1, 4'h0, 1, 0, 0, 0, 0, AC, 0, 32'h80, 32'h0);
    // Reset while in service with PENDING=A (ack races a new line-1 edge)
    add(1, 4'h0, 0, 0, 1, AM, 32'h2, AM, 0, 32'h80, 32'h2);
    add(1, 4'hA, 0, 0, 0, 0, 0, AP, 0, 32'h80, 32'h0);
    add(1, 4'h0, 0, 0, 0, 0, 0, AP, 0, 32'h80, 32'h0);
    add(1, 4'h2, 0, 0, 0, 0, 0, AP, 0, 32'h80, 32'hA);
    add(1, 4'h0, 0, 0, 0, 0, 0, AC, 1, 32'h90, 32'h1);
    add(1, 4'h0, 1, 0, 0, 0, 0, AP, 0, 32'h90, 32'hA);
    add(1, 4'h0, 0, 0, 1, AV, 32'h1003, AV, 0, 32'h90, 32'h1000);
    add(1, 4'h0, 0, 0, 0, 0, 0, AC, 0, 32'h90, 32'h8000_0001);
    add(0, 4'h0, 0, 0, 0, 0, 0, AP, 0, 32'h80, 32'h0);
    add(1, 4'h0, 0, 0, 0, 0, 0, AV, 0, 32'h80, 32'h80);
    add(1, 4'h0, 0, 0, 0, 0, 0, AC, 0, 32'h80, 32'h0);
    // Writes outside the window are ignored
    add(1, 4'h0, 0, 0, 1, 32'h810, 32'hFFFF_FFFF, AM, 0, 32'h80, 32'h0);
    add(1, 4'h0, 0, 0, 1, 32'h7FC, 32'hFFFF_FFFF, 32'h810, 0, 32'h80, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; irq_in = tbl[i].irq; int_ack = tbl[i].ack; eoi = tbl[i].eo;
      bus_we = tbl[i].we; bus_addr = tbl[i].waddr; bus_wdata = tbl[i].wdata;
      @(posedge clk); #1;
      int_ack = 0; eoi = 0; bus_we = 0; bus_addr = tbl[i].raddr;
      #1;
      chk($sformatf("row%0d interrupt", i), {31'h0, interrupt}, {31'h0, tbl[i].exp_int});
      chk($sformatf("row%0d vector", i), vector, tbl[i].exp_vec);
      chk($sformatf("row%0d rdata@%h", i, tbl[i].raddr), bus_rdata, tbl[i].exp_rd);
      $display("row %0d: addr=%h rdata=%h int=%0d vec=%h", i, tbl[i].raddr, bus_rdata, interrupt, vector);
    end
    chk("hit outside", {31'h0, bus_hit}, 32'h0);

    // ---------------- randomized run against the model ----------------
    for (int n = 0; n < 3000; n++) begin
      reset   = (n == 0 || $urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      irq_in  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      int_ack = ($urandom_range(0, 3) == 0);
      eoi     = ($urandom_range(0, 3) == 0);
      bus_we  = ($urandom_range(0, 4) == 0);
      bus_wdata = $urandom;
      case ($urandom_range(0, 7))
        0:       bus_addr = $urandom;
        1:       bus_addr = BASE + 32'd16 + 32'(4 * $urandom_range(0, 3));
        2:       bus_addr = BASE - 32'd4;
        default: bus_addr = BASE + 32'(4 * $urandom_range(0, 3));
      endcase
      #1;
      if (model_ok) begin
        chk($sformatf("rnd%0d hit@%h", n, bus_addr), {31'h0, bus_hit},
            {31'h0, ((bus_addr - BASE) < 32'd16)});
        chk($sformatf("rnd%0d rdata@%h", n, bus_addr), bus_rdata, model_rd(bus_addr));
      end
      model_step();
      @(posedge clk); #1;
      chk($sformatf("rnd%0d interrupt", n), {31'h0, interrupt}, {31'h0, m_int});
      chk($sformatf("rnd%0d vector", n), vector, m_vec);
      if (n % 100 == 0)
        $display("rnd %0d: int=%0d vec=%h pend=%h mask=%h", n, interrupt, vector, m_pend, m_mask);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
